// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multi-cycle RV32I-subset control unit.
package multicycle_pkg;

  // Control states; the numeric encodings are exported on state_dbg.
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_ALU   = 4'd7,
    WB_MEM   = 4'd8,
    BRANCH   = 4'd9,
    HALT     = 4'd10
  } state_t;

  // Opcodes of the supported instruction classes.
  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_SD  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;

  // Commands for the external ALU control decoder.
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // ALU operand B selects.
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Moore control FSM sequencing the shared ALU, PC, IR and unified memory
// of the multi-cycle core. Outputs decode the state register; only the
// FETCH-state IR/PC strobes look at mem_ready so a stalled fetch loads nothing.
module multicycle_control
  import multicycle_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_source,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  state_t state;
  state_t next_state;

  // State register; reset drops any in-flight instruction or memory request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Sticky illegal flag, raised on the same edge that enters HALT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal <= 1'b0;
    end else if (next_state == HALT) begin
      illegal <= 1'b1;
    end
  end

  // Next-state logic; opcode matters only in DECODE and MEM_ADDR.
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:    next_state = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OPC_R:          next_state = EXEC_R;
          OPC_I:          next_state = EXEC_I;
          OPC_LD, OPC_SD: next_state = MEM_ADDR;
          OPC_BEQ:        next_state = BRANCH;
          default:        next_state = HALT;
        endcase
      end
      EXEC_R:   next_state = WB_ALU;
      EXEC_I:   next_state = WB_ALU;
      MEM_ADDR: begin
        if (opcode == OPC_LD) begin
          next_state = MEM_RD;
        end else if (opcode == OPC_SD) begin
          next_state = MEM_WR;
        end else begin
          next_state = HALT;
        end
      end
      MEM_RD:   next_state = mem_ready ? WB_MEM : MEM_RD;
      MEM_WR:   next_state = mem_ready ? FETCH : MEM_WR;
      WB_ALU:   next_state = FETCH;
      WB_MEM:   next_state = FETCH;
      BRANCH:   next_state = FETCH;
      HALT:     next_state = HALT;
      default:  next_state = FETCH;
    endcase
  end

  // Control outputs decoded from the current state.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    ir_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALU_ADD;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b = SRCB_IMM;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      WB_ALU: begin
        reg_write = 1'b1;
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the stimulus side expands each
// instruction into its expected per-cycle state/output trace and queues it,
// while a monitor pops and compares one entry per clock on the falling edge.
module tb_multicycle_control;
  import multicycle_pkg::*;

  logic       clk;
  logic       reset_n;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, pc_source, ir_write, iord;
  logic       mem_read, mem_write, alu_src_a, reg_write, mem_to_reg, illegal;
  logic [1:0] alu_src_b, alu_op;
  logic [3:0] state_dbg;

  typedef struct packed {
    logic [3:0]  st;
    logic [14:0] outs;
  } exp_t;

  exp_t sb_q[$];
  int   assert_count = 0;
  int   fail_count   = 0;
  int   cycle_count  = 0;

  multicycle_control dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .ir_write(ir_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .illegal(illegal),
    .state_dbg(state_dbg)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [14:0] dut_outs = {pc_write, pc_write_cond, pc_source, ir_write, iord,
                          mem_read, mem_write, alu_src_a, alu_src_b, alu_op,
                          reg_write, mem_to_reg, illegal};

  // Per-state control values as listed in the state table of the design.
  function automatic logic [14:0] exp_outs(input int st, input logic mr);
    logic pw, pwc, psrc, irw, ad, rd, wr, sa, rw, m2r;
    logic [1:0] sb, op;
    {pw, pwc, psrc, irw, ad, rd, wr, sa, rw, m2r} = '0;
    sb = 2'b00;
    op = 2'b00;
    case (st)
      0: begin rd = 1'b1; sb = 2'b01; irw = mr; pw = mr; end
      1: sb = 2'b10;
      2: begin sa = 1'b1; op = 2'b10; end
      3: begin sa = 1'b1; sb = 2'b10; op = 2'b10; end
      4: begin sa = 1'b1; sb = 2'b10; end
      5: begin rd = 1'b1; ad = 1'b1; end
      6: begin wr = 1'b1; ad = 1'b1; end
      7: rw = 1'b1;
      8: begin rw = 1'b1; m2r = 1'b1; end
      9: begin sa = 1'b1; op = 2'b01; pwc = 1'b1; psrc = 1'b1; end
      default: ;
    endcase
    return {pw, pwc, psrc, irw, ad, rd, wr, sa, sb, op, rw, m2r, 1'(st == 10)};
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return op == OPC_R || op == OPC_I || op == OPC_LD || op == OPC_SD || op == OPC_BEQ;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s at %0t: got 0x%h, expected 0x%h", name, $time, actual, expected);
    end
  endtask

  // Expand one instruction into its cycle trace, then drive it cycle by cycle.
  // Called in the slot 1 time unit after a rising edge; returns in the same slot.
  // fw/mw: wait cycles in FETCH / memory state; hold: cycles spent in HALT;
  // limit: stop after this many cycles (negative = whole instruction).
  task automatic applyStimulus(input logic [6:0] op, input int fw, input int mw,
                               input int hold, input int limit);
    int   st_q[$];
    logic mr_q[$];
    repeat (fw) begin st_q.push_back(0); mr_q.push_back(1'b0); end
    st_q.push_back(0); mr_q.push_back(1'b1);
    st_q.push_back(1); mr_q.push_back(1'($urandom));
    if (op == OPC_R || op == OPC_I) begin
      st_q.push_back(op == OPC_R ? 2 : 3); mr_q.push_back(1'($urandom));
      st_q.push_back(7); mr_q.push_back(1'($urandom));
    end else if (op == OPC_LD || op == OPC_SD) begin
      st_q.push_back(4); mr_q.push_back(1'($urandom));
      repeat (mw) begin st_q.push_back(op == OPC_LD ? 5 : 6); mr_q.push_back(1'b0); end
      st_q.push_back(op == OPC_LD ? 5 : 6); mr_q.push_back(1'b1);
      if (op == OPC_LD) begin st_q.push_back(8); mr_q.push_back(1'($urandom)); end
    end else if (op == OPC_BEQ) begin
      st_q.push_back(9); mr_q.push_back(1'($urandom));
    end else begin
      repeat (hold) begin st_q.push_back(10); mr_q.push_back(1'($urandom)); end
    end
    for (int i = 0; i < st_q.size() && (limit < 0 || i < limit); i++) begin
      opcode    = (st_q[i] == 0) ? 7'($urandom) : op;
      mem_ready = mr_q[i];
      sb_q.push_back('{st: 4'(st_q[i]), outs: exp_outs(st_q[i], mr_q[i])});
      cycle_count++;
      @(posedge clk);
      #1;
    end
  endtask

  // Asynchronous reset pulse asserted mid-cycle, checked before the next edge.
  task automatic doReset(input string tag);
    #1 reset_n = 1'b0;
    #1;
    checkOutput({tag, "_state"}, 16'(state_dbg), 16'd0);
    checkOutput({tag, "_outs"}, 16'(dut_outs), 16'(exp_outs(0, mem_ready)));
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Monitor: invariants every cycle, plus one scoreboard entry when queued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      checkOutput("rd_wr_exclusive", 16'(mem_read & mem_write), 16'd0);
      checkOutput("pc_wr_exclusive", 16'(pc_write & pc_write_cond), 16'd0);
      checkOutput("state_in_range", 16'(state_dbg > 4'd10), 16'd0);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput("state", 16'(state_dbg), 16'(e.st));
        checkOutput("outputs", 16'(dut_outs), 16'(e.outs));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, got %0d cycles, expected completion", cycle_count);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [6:0] bad_op;
    int         pick;
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    opcode    = OPC_R;
    #1;
    checkOutput("reset_state", 16'(state_dbg), 16'd0);
    checkOutput("reset_outs", 16'(dut_outs), 16'(exp_outs(0, 1'b1)));
    @(posedge clk);
    #1 reset_n = 1'b1;

    $display("[TB] R-type after reset");
    applyStimulus(OPC_R, 0, 0, 0, -1);
    $display("[TB] load with fetch and read stalls");
    applyStimulus(OPC_LD, 2, 1, 0, -1);
    $display("[TB] store then beq");
    applyStimulus(OPC_SD, 0, 0, 0, -1);
    applyStimulus(OPC_BEQ, 0, 0, 0, -1);
    $display("[TB] illegal opcode into HALT");
    applyStimulus(7'b1111111, 0, 0, 20, -1);
    doReset("halt_reset");
    applyStimulus(OPC_I, 0, 0, 0, -1);
    $display("[TB] reset during stalled store");
    applyStimulus(OPC_SD, 0, 5, 0, 5);
    checkOutput("mem_write_pending", 16'(mem_write), 16'd1);
    doReset("memwr_reset");
    applyStimulus(OPC_R, 1, 0, 0, -1);

    $display("[TB] random run");
    while (cycle_count < 10000) begin
      pick = int'($urandom_range(0, 11));
      case (pick)
        0, 1:    applyStimulus(OPC_R,   $urandom_range(0, 3), 0, 0, -1);
        2, 3:    applyStimulus(OPC_I,   $urandom_range(0, 3), 0, 0, -1);
        4, 5:    applyStimulus(OPC_LD,  $urandom_range(0, 3), $urandom_range(0, 3), 0, -1);
        6, 7:    applyStimulus(OPC_SD,  $urandom_range(0, 3), $urandom_range(0, 3), 0, -1);
        8, 9:    applyStimulus(OPC_BEQ, $urandom_range(0, 3), 0, 0, -1);
        10: begin
          bad_op = 7'($urandom);
          while (is_legal(bad_op)) bad_op = 7'($urandom);
          applyStimulus(bad_op, $urandom_range(0, 3), 0, $urandom_range(1, 20), -1);
          doReset("rand_halt_reset");
        end
        default: applyStimulus(OPC_R, 0, 0, 0, -1);
      endcase
    end

    checkOutput("queue_drained", 16'(sb_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore FSM control unit for the multi-cycle variant of the RV32I-subset core.
- Sequences the shared ALU, PC, IR and unified memory over several cycles per instruction, and drives ALUOp into the existing ALU control decoder.
- Supports R-type, addi-class I-type, ld, sd and beq.
- Stalls on a ready handshake with instruction/data memory.

Parameters:
- OPC_R, 7'b0110011, R-type opcode
- OPC_I, 7'b0010011, ALU-immediate opcode
- OPC_LD, 7'b0000011, load opcode
- OPC_SD, 7'b0100011, store opcode
- OPC_BEQ, 7'b1100011, branch-equal opcode

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- opcode  in  7  IR[6:0], valid from DECODE onward
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU Zero (datapath ANDs)
- pc_source  out  1  0=ALU result, 1=ALUOut register
- ir_write  out  1  latch fetched word into IR
- iord  out  1  memory address: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- alu_src_a  out  1  0=old PC, 1=rs1
- alu_src_b  out  2  00=rs2, 01=const 4, 10=imm
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded
- reg_write  out  1  register file write
- mem_to_reg  out  1  writeback select: 0=ALUOut, 1=MDR
- illegal  out  1  sticky illegal-opcode flag
- state_dbg  out  4  current state encoding

Behaviour:
- Reset: reset_n low forces state FETCH immediately, regardless of clk.
  - Reset applies mid-instruction too, including while a memory request is pending; the request is dropped.
  - illegal clears to 0.
  - All other outputs take FETCH-state values below; reset does not suppress them.
- Outputs are pure decode of the state register, except ir_write and pc_write in FETCH, which are gated by mem_ready.
- Outputs not listed for a state are 0. alu_op and alu_src_b default to 00.
- States and encodings, used for state_dbg:
  - FETCH=0: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=0; ir_write=pc_write=mem_ready.
    - Stays in FETCH while mem_ready=0; no IR/PC update during the stall. Moves to DECODE on mem_ready=1.
  - DECODE=1: alu_src_a=0, alu_src_b=10, alu_op=00, precomputing the branch target into ALUOut. Next state by opcode:
    - R -> EXEC_R
    - I -> EXEC_I
    - LD or SD -> MEM_ADDR
    - BEQ -> BRANCH
    - any other opcode -> HALT
  - EXEC_R=2: alu_src_a=1, alu_src_b=00, alu_op=10 -> WB_ALU.
  - EXEC_I=3: alu_src_a=1, alu_src_b=10, alu_op=10 -> WB_ALU.
  - MEM_ADDR=4: alu_src_a=1, alu_src_b=10, alu_op=00 -> MEM_RD if LD, MEM_WR if SD.
  - MEM_RD=5: mem_read=1, iord=1. Holds until mem_ready, then -> WB_MEM.
  - MEM_WR=6: mem_write=1, iord=1. Holds until mem_ready, then -> FETCH.
  - WB_ALU=7: reg_write=1, mem_to_reg=0 -> FETCH.
  - WB_MEM=8: reg_write=1, mem_to_reg=1 -> FETCH.
  - BRANCH=9: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=1 -> FETCH.
  - HALT=10: illegal=1 (registered, set on entry). All write/request outputs are 0. Only reset_n exits HALT.
  - Encodings 11-15 are unreachable; if entered, go to FETCH next cycle.
- opcode is sampled only in DECODE and MEM_ADDR. IR is stable from DECODE to end of instruction, because ir_write is asserted only in FETCH.
- Latency with zero-wait memory (mem_ready held 1):
  - R/I: 4 cycles
  - LD: 5 cycles
  - SD: 4 cycles
  - BEQ: 3 cycles
- Each mem_ready-low cycle in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- mem_ready outside FETCH, MEM_RD and MEM_WR is ignored.
- At most one of mem_read and mem_write is high in any cycle.
- pc_write and pc_write_cond are never high in the same cycle.

Decomposition:
- Package multicycle_pkg:
  - state_t enum (4-bit, encodings above)
  - opcode localparams
  - alu_op constants: ALU_ADD=00, ALU_SUB=01, ALU_FUNCT=10
  - alu_src_b constants: SRCB_RS2, SRCB_FOUR, SRCB_IMM
- Split into a next-state always_ff/always_comb pair plus an output-decode always_comb in the same module.
- No sub-module needed. The existing ALU control decoder stays external, driven by alu_op.

Test Plan:
- Reset with mem_ready=1, opcode=OPC_R: release reset_n -> FETCH (state_dbg=0), ir_write=pc_write=1; state sequence 0,1,2,7,0; reg_write=1 only in cycle 4.
- Load with mem_ready low 2 cycles in FETCH and 1 cycle in MEM_RD, opcode=OPC_LD: state sequence 0,0,0,1,4,5,5,8,0; ir_write pulses exactly once; mem_to_reg=1 in WB_MEM.
- Store then beq back to back:
  - SD: sequence 0,1,4,6,0, with mem_write=1 only in state 6 and iord=1.
  - BEQ: sequence 0,1,9,0, with alu_op=01, pc_write_cond=1, pc_source=1 in state 9.
- Illegal opcode 7'b1111111 in DECODE: next state HALT(10) and illegal=1 held 20 cycles under any mem_ready; no mem/reg/pc writes. Then pulse reset_n low mid-cycle: state 0 and illegal=0 asynchronously, before the next clk edge.
- Reset during MEM_WR with mem_ready=0: assert reset_n=0 -> mem_write drops immediately, state_dbg=0. After release, normal fetch resumes.
- Assertions held throughout a 10k-cycle random opcode/mem_ready run:
  - mem_read & mem_write never both high
  - pc_write & pc_write_cond never both high
  - state_dbg never 11-15
